// File: rtl/cfu_pkg.sv
// Shared definitions for the SIMD MAC CFU.
// Function ids and FSM state encoding.
package cfu_pkg;

  localparam logic [2:0] FN_PASS0   = 3'd0;
  localparam logic [2:0] FN_PASS1   = 3'd1;
  localparam logic [2:0] FN_SET_ACC = 3'd2;
  localparam logic [2:0] FN_MAC     = 3'd3;
  localparam logic [2:0] FN_GET_ACC = 3'd4;
  localparam logic [2:0] FN_SET_OFF = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/cfu_simd_dot.sv
// Combinational signed SIMD dot product with input offset.
// Lane 0 sits in the low bits of each operand.
module cfu_simd_dot #(
  parameter int LANE_W = 8,
  parameter int LANES  = 4,
  parameter int OFF_W  = 9,
  parameter int ACC_W  = 32
) (
  input  logic [LANES*LANE_W-1:0] a,
  input  logic [LANES*LANE_W-1:0] b,
  input  logic [OFF_W-1:0]        offset,
  output logic [ACC_W-1:0]        dot
);

  localparam int P_W = OFF_W + LANE_W;

  // Sum of per-lane (sext(a)+offset)*sext(b), wrapping at ACC_W
  always_comb begin
    logic signed [OFF_W-1:0] av;
    logic signed [P_W-1:0]   aw;
    logic signed [P_W-1:0]   bw;
    logic signed [P_W-1:0]   p;
    av  = '0;
    aw  = '0;
    bw  = '0;
    p   = '0;
    dot = '0;
    for (int i = 0; i < LANES; i++) begin
      av = {{(OFF_W-LANE_W){a[i*LANE_W+LANE_W-1]}},
            a[i*LANE_W +: LANE_W]} + offset;
      aw = P_W'(av);
      bw = {{(P_W-LANE_W){b[i*LANE_W+LANE_W-1]}},
            b[i*LANE_W +: LANE_W]};
      p  = aw * bw;
      dot = dot + {{(ACC_W-P_W){p[P_W-1]}}, p};
    end
  end

endmodule

// File: rtl/cfu_simd_mac.sv
// Multi-cycle SIMD multiply-accumulate CFU.
// One command in flight, fixed latency, back-pressured response.
module cfu_simd_mac
  import cfu_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int LANE_W  = 8,
  parameter int LANES   = 4,
  parameter int ACC_W   = 32,
  parameter int OFF_W   = 9,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              io_bus_cmd_valid,
  output logic              io_bus_cmd_ready,
  input  logic [2:0]        io_bus_cmd_payload_function_id,
  input  logic [DATA_W-1:0] io_bus_cmd_payload_inputs_0,
  input  logic [DATA_W-1:0] io_bus_cmd_payload_inputs_1,
  output logic              io_bus_rsp_valid,
  input  logic              io_bus_rsp_ready,
  output logic              io_bus_rsp_payload_response_ok,
  output logic [DATA_W-1:0] io_bus_rsp_payload_outputs_0
);

  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  state_t            state;
  state_t            next;
  logic [3:0]        cnt;
  logic [2:0]        fn_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [ACC_W-1:0]  acc;
  logic [OFF_W-1:0]  offset;

  logic              accept;
  logic              enter_resp;
  logic [2:0]        fn_c;
  logic [DATA_W-1:0] a_c;
  logic [DATA_W-1:0] b_c;
  logic [ACC_W-1:0]  dot;
  logic [DATA_W-1:0] res;
  logic              ok_n;
  logic              acc_we;
  logic              off_we;

  assign accept = io_bus_cmd_valid & io_bus_cmd_ready;

  // Operands come straight off the bus when latency 1 skips BUSY
  assign fn_c = (state == ST_IDLE) ? io_bus_cmd_payload_function_id : fn_q;
  assign a_c  = (state == ST_IDLE) ? io_bus_cmd_payload_inputs_0 : a_q;
  assign b_c  = (state == ST_IDLE) ? io_bus_cmd_payload_inputs_1 : b_q;

  cfu_simd_dot #(
    .LANE_W (LANE_W),
    .LANES  (LANES),
    .OFF_W  (OFF_W),
    .ACC_W  (ACC_W)
  ) u_dot (
    .a      (a_c),
    .b      (b_c),
    .offset (offset),
    .dot    (dot)
  );

  // Next-state logic
  always_comb begin
    next = state;
    unique case (state)
      ST_IDLE: if (accept)
                 next = (LATENCY == 1) ? ST_RESP : ST_BUSY;
      ST_BUSY: if (cnt == 4'd1) next = ST_RESP;
      ST_RESP: if (io_bus_rsp_ready) next = ST_IDLE;
      default: next = ST_IDLE;
    endcase
  end

  assign enter_resp = (next == ST_RESP) && (state != ST_RESP);

  // Function decode: result, status and state-write enables
  always_comb begin
    res    = '0;
    ok_n   = 1'b1;
    acc_we = 1'b0;
    off_we = 1'b0;
    unique case (1'b1)
      (fn_c == FN_PASS0):   res = a_c;
      (fn_c == FN_PASS1):   res = b_c;
      (fn_c == FN_SET_ACC): begin
        res    = a_c;
        acc_we = 1'b1;
      end
      (fn_c == FN_MAC): begin
        res    = acc + dot;
        acc_we = 1'b1;
      end
      (fn_c == FN_GET_ACC): res = acc;
      (fn_c == FN_SET_OFF): begin
        res    = a_c;
        off_we = 1'b1;
      end
      default: ok_n = 1'b0;
    endcase
  end

  // FSM state, ready flag and latency counter
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state            <= ST_IDLE;
      io_bus_cmd_ready <= 1'b1;
      cnt              <= '0;
      fn_q             <= '0;
      a_q              <= '0;
      b_q              <= '0;
    end else begin
      state            <= next;
      io_bus_cmd_ready <= (next == ST_IDLE);
      if (accept) begin
        cnt  <= CNT_LOAD;
        fn_q <= io_bus_cmd_payload_function_id;
        a_q  <= io_bus_cmd_payload_inputs_0;
        b_q  <= io_bus_cmd_payload_inputs_1;
      end else if (state == ST_BUSY) begin
        cnt <= cnt - 4'd1;
      end
    end
  end

  // Commit result and architectural state once, on entering RESP
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      acc                            <= '0;
      offset                         <= '0;
      io_bus_rsp_valid               <= 1'b0;
      io_bus_rsp_payload_response_ok <= 1'b0;
      io_bus_rsp_payload_outputs_0   <= '0;
    end else if (enter_resp) begin
      io_bus_rsp_valid               <= 1'b1;
      io_bus_rsp_payload_response_ok <= ok_n;
      io_bus_rsp_payload_outputs_0   <= res;
      if (acc_we) acc <= res;
      if (off_we) offset <= a_c[OFF_W-1:0];
    end else if (state == ST_RESP && io_bus_rsp_ready) begin
      io_bus_rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cfu_simd_mac.sv
// Directed self-checking bench for cfu_simd_mac.
// Scenario tasks run in sequence from one initial block.
module tb_cfu_simd_mac;

  logic        clk = 1'b0;
  logic        resetn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  fn;
  logic [31:0] in0;
  logic [31:0] in1;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        ok;
  logic [31:0] out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cfu_simd_mac #(.LATENCY(2)) dut (
    .clk                            (clk),
    .resetn                         (resetn),
    .io_bus_cmd_valid               (cmd_valid),
    .io_bus_cmd_ready               (cmd_ready),
    .io_bus_cmd_payload_function_id (fn),
    .io_bus_cmd_payload_inputs_0    (in0),
    .io_bus_cmd_payload_inputs_1    (in1),
    .io_bus_rsp_valid               (rsp_valid),
    .io_bus_rsp_ready               (rsp_ready),
    .io_bus_rsp_payload_response_ok (ok),
    .io_bus_rsp_payload_outputs_0   (out)
  );

  // Issue one command and collect its response
  task automatic send(input logic [2:0] f, input logic [31:0] a,
                      input logic [31:0] b, output logic [31:0] r,
                      output logic r_ok);
    int n;
    @(negedge clk);
    fn = f; in0 = a; in1 = b; cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!rsp_valid) begin
      errors++;
      $display("FAIL rsp_timeout fn=%0d got rsp_valid=0 need 1", f);
    end
    r = out;
    r_ok = ok;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] r;
    logic        k;
    resetn = 1'b0;
    cmd_valid = 1'b0; rsp_ready = 1'b0;
    fn = '0; in0 = '0; in1 = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 ||
        out !== 32'h0 || ok !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got rdy=%b v=%b out=%h ok=%b need 1 0 0 0",
               cmd_ready, rsp_valid, out, ok);
    end
    resetn = 1'b1;
    @(negedge clk);
    send(3'd4, 32'h0, 32'h0, r, k);
    checks++;
    if (r !== 32'h0 || k !== 1'b1) begin
      errors++;
      $display("FAIL get_acc_reset got %h ok=%b need 00000000 ok=1", r, k);
    end
  endtask

  task automatic test_latency();
    @(negedge clk);
    fn = 3'd1; in0 = 32'h1111_1111; in1 = 32'hDEAD_BEEF;
    cmd_valid = 1'b1;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    in1 = 32'h0BAD_0BAD;
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL latency_n got v=%b rdy=%b need 0 0",
               rsp_valid, cmd_ready);
    end
    rsp_ready = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (rsp_valid !== 1'b1 || out !== 32'hDEAD_BEEF || ok !== 1'b1) begin
      errors++;
      $display("FAIL latency_n1 got v=%b out=%h need 1 deadbeef",
               rsp_valid, out);
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  task automatic test_mac();
    logic [31:0] r;
    logic        k;
    send(3'd2, 32'h0, 32'h0, r, k);
    send(3'd3, 32'h0102_0304, 32'h0101_0101, r, k);
    checks++;
    if (r !== 32'h0000_000A) begin
      errors++;
      $display("FAIL mac_pos got %h need 0000000a", r);
    end
    send(3'd3, 32'h0102_0304, 32'hFFFF_FFFF, r, k);
    checks++;
    if (r !== 32'h0) begin
      errors++;
      $display("FAIL mac_neg got %h need 00000000", r);
    end
  endtask

  task automatic test_offset();
    logic [31:0] r;
    logic        k;
    send(3'd2, 32'h0000_0005, 32'h0, r, k);
    send(3'd5, 32'h0000_0080, 32'h0, r, k);
    checks++;
    if (r !== 32'h0000_0080 || k !== 1'b1) begin
      errors++;
      $display("FAIL set_off got %h need 00000080", r);
    end
    send(3'd3, 32'h8080_8080, 32'h7F7F_7F7F, r, k);
    checks++;
    if (r !== 32'h0000_0005) begin
      errors++;
      $display("FAIL mac_off128 got %h need 00000005", r);
    end
    send(3'd5, 32'h0000_01FF, 32'h0, r, k);
    send(3'd2, 32'h0, 32'h0, r, k);
    send(3'd3, 32'h03FF_0201, 32'h0101_0101, r, k);
    checks++;
    if (r !== 32'h0000_0001) begin
      errors++;
      $display("FAIL mac_offm1 got %h need 00000001", r);
    end
    send(3'd5, 32'h0, 32'h0, r, k);
  endtask

  task automatic test_wrap();
    logic [31:0] r;
    logic        k;
    send(3'd2, 32'h7FFF_FFFF, 32'h0, r, k);
    send(3'd3, 32'h0000_0001, 32'h0000_0001, r, k);
    checks++;
    if (r !== 32'h8000_0000) begin
      errors++;
      $display("FAIL mac_wrap got %h need 80000000", r);
    end
  endtask

  task automatic test_backpressure();
    int n;
    @(negedge clk);
    fn = 3'd0; in0 = 32'h1234_5678; in1 = 32'h0;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    fn = 3'd1; in1 = 32'hCAFE_F00D;
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || cmd_ready !== 1'b0 ||
          out !== 32'h1234_5678) begin
        errors++;
        $display("FAIL hold_%0d got v=%b rdy=%b out=%h need 1 0 12345678",
                 i, rsp_valid, cmd_ready, out);
      end
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL release got v=%b rdy=%b need 0 1",
               rsp_valid, cmd_ready);
    end
  endtask

  task automatic test_illegal();
    logic [31:0] r;
    logic        k;
    send(3'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, k);
    checks++;
    if (r !== 32'h0 || k !== 1'b0) begin
      errors++;
      $display("FAIL fn6 got %h ok=%b need 00000000 ok=0", r, k);
    end
    send(3'd7, 32'h1, 32'h1, r, k);
    checks++;
    if (r !== 32'h0 || k !== 1'b0) begin
      errors++;
      $display("FAIL fn7 got %h ok=%b need 00000000 ok=0", r, k);
    end
    send(3'd4, 32'h0, 32'h0, r, k);
    checks++;
    if (r !== 32'h8000_0000 || k !== 1'b1) begin
      errors++;
      $display("FAIL acc_kept got %h need 80000000", r);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] r;
    logic        k;
    @(negedge clk);
    fn = 3'd2; in0 = 32'h5555_5555; cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    resetn = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset got v=%b rdy=%b need 0 1",
               rsp_valid, cmd_ready);
    end
    @(negedge clk);
    resetn = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_no_rsp got v=%b need 0", rsp_valid);
    end
    send(3'd4, 32'h0, 32'h0, r, k);
    checks++;
    if (r !== 32'h0) begin
      errors++;
      $display("FAIL mid_acc got %h need 00000000", r);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r;
    logic        k;
    send(3'd2, 32'h0000_0010, 32'h0, r, k);
    send(3'd3, 32'h0000_0002, 32'h0000_0003, r, k);
    send(3'd3, 32'hFE00_0000, 32'h0400_0000, r, k);
    checks++;
    if (r !== 32'h0000_000E) begin
      errors++;
      $display("FAIL b2b_mac got %h need 0000000e", r);
    end
    send(3'd0, 32'hA5A5_A5A5, 32'h0, r, k);
    checks++;
    if (r !== 32'hA5A5_A5A5 || k !== 1'b1) begin
      errors++;
      $display("FAIL pass0 got %h need a5a5a5a5", r);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_mac();
    test_offset();
    test_wrap();
    test_backpressure();
    test_illegal();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
